fft_reorder: RTL and testbench
==============================

Name: fft_reorder

Overview:
- Output stage directly downstream of the final butterfly stage of the 16-point FFT.
- The final stage delivers packed complex results in bit-reversed index order, one word per accepted cycle.
- This block reorders them into natural frequency order (X[0]..X[N-1]) and streams them to the analysis/output logic over a valid/ready handshake.
- A ping-pong pair of frame buffers lets one frame be written while the previous one is read.

Parameters:
- N_LOG2, 4, log2 of the FFT size; frame length N = 2^N_LOG2.
- DW, 32, data width; packed {real[31:16], imag[15:0]}, both signed 16-bit. Passed through untouched.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data is valid this cycle.
- in_data  input  DW  FFT result word, arriving in bit-reversed order.
- in_ready  output  1  block can accept in_data this cycle.
- out_valid  output  1  out_data is valid.
- out_data  output  DW  result word, natural order.
- out_ready  input  1  consumer accepts out_data this cycle.
- out_index  output  N_LOG2  frequency bin index of out_data.
- out_last  output  1  high with the final word (index N-1) of a frame.

Behaviour:
- Storage:
  - Two banks, each N x DW registers. Not reset; contents are don't-care until written.
- State:
  - wr_bank, rd_bank: 1 bit each.
  - wr_cnt, rd_cnt: N_LOG2 bits each.
  - full[1:0]: 2 bits.
- Reset (async, rst=1):
  - wr_bank=rd_bank=0, wr_cnt=rd_cnt=0, full=2'b00.
  - Hence in_ready=1, out_valid=0, out_index=0, out_last=0.
  - out_data is don't-care while out_valid=0.
- Write side:
  - in_ready = !full[wr_bank] (combinational from state only).
  - Accept = in_valid && in_ready.
  - On accept: bank[wr_bank][bitrev(wr_cnt)] <= in_data, then wr_cnt++.
  - On accept with wr_cnt==N-1: full[wr_bank] <= 1, wr_bank toggles, wr_cnt wraps to 0.
- Read side:
  - out_valid = full[rd_bank].
  - out_data = bank[rd_bank][rd_cnt] (combinational read of the register array).
  - out_index = rd_cnt; out_last = out_valid && rd_cnt==N-1.
  - Transfer = out_valid && out_ready: rd_cnt++.
  - On transfer with rd_cnt==N-1: full[rd_bank] <= 0, rd_bank toggles, rd_cnt wraps to 0.
  - out_data/out_index must stay stable while out_valid=1 and out_ready=0.
- bitrev: reverse the N_LOG2 bits of the counter. Example for N=16: 1->8, 3->12.
- Latency:
  - First out_valid is asserted the cycle after the N-th input is accepted.
  - Steady state: 1 word/cycle in and out, with out_ready held high and in_valid continuous.
- Simultaneous events:
  - A write that fills one bank and a read that empties the other bank in the same cycle both take effect: the full bits update independently.
  - Both banks full: in_ready=0. in_ready returns to 1 the cycle after the read side frees a bank.
  - Writes never target a full bank. Reads never target a non-full bank.
- Reset mid-frame: all partial frames are discarded and the block returns to the reset state immediately. The next accepted word is bin-0 of a new frame.
- No arithmetic, scaling or saturation; words pass bit-exact.
- in_data is ignored when in_ready=0, even if in_valid=1 (upstream must hold it).

Test Plan:
- Single frame, out_ready=1:
  - Stimulus: feed words 0..15 (data=k) on 16 consecutive cycles.
  - Required: out_data sequence 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 with out_index 0..15.
  - Required: out_last only on the 16th word; out_valid rises exactly 1 cycle after the 16th accept.
- Continuous streaming:
  - Stimulus: 4 back-to-back frames (frame f word k = {f[15:0], k[15:0]}), out_ready=1.
  - Required: in_ready never drops; outputs contiguous, frames in order, each reordered as above.
- Backpressure:
  - Stimulus: out_ready=0 while 2 full frames plus 1 extra word are offered.
  - Required: in_ready=0 after the 32nd accept; the extra word is held off.
  - Required: out_data stays frame-0 bin-0, stable.
  - Then out_ready=1: in_ready returns the cycle after the 16th read, and the extra word is accepted into the freed bank.
- Random stall:
  - Stimulus: random in_valid and random out_ready (50%) over 20 frames.
  - Required: the scoreboard matches the bit-reversal model with no loss or duplication.
- Reset mid-operation:
  - Stimulus: assert rst asynchronously after 7 words of frame 1 while frame 0 is half read.
  - Required: out_valid=0 and in_ready=1 immediately.
  - Required: the next 16 inputs produce a correct frame with out_index starting at 0.
- Signed extremes:
  - Stimulus: words 32'h8000_7FFF and 32'h7FFF_8000 at input positions 1 and 3.
  - Required: they emerge bit-exact at out_index 8 and 12.

Source files
------------

// File: rtl/fft_reorder.sv
// rtl/fft_reorder.sv - ping-pong bit-reversed to natural order FFT output reorder buffer
module fft_reorder #(
    parameter int N_LOG2 = 4,
    parameter int DW     = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    input  logic [DW-1:0]     in_data,
    output logic              in_ready,
    output logic              out_valid,
    output logic [DW-1:0]     out_data,
    input  logic              out_ready,
    output logic [N_LOG2-1:0] out_index,
    output logic              out_last
);

    localparam int N = 1 << N_LOG2;

    logic [DW-1:0]     mem [2][N];
    logic              wr_bank;
    logic              rd_bank;
    logic [N_LOG2-1:0] wr_cnt;
    logic [N_LOG2-1:0] rd_cnt;
    logic [1:0]        full;
    logic [1:0]        full_nxt;
    logic              accept;
    logic              xfer;

    function automatic logic [N_LOG2-1:0] bitrev(input logic [N_LOG2-1:0] v);
        logic [N_LOG2-1:0] r;
        for (int i = 0; i < N_LOG2; i++) begin
            r[i] = v[N_LOG2-1-i];
        end
        return r;
    endfunction

    // Handshake and read-port decode; all derived from registered state.
    always_comb begin
        in_ready  = !full[wr_bank];
        out_valid = full[rd_bank];
        accept    = in_valid && in_ready;
        xfer      = out_valid && out_ready;
        out_data  = mem[rd_bank][rd_cnt];
        out_index = rd_cnt;
        out_last  = out_valid && (rd_cnt == '1);
    end

    // Frame storage: scatter incoming words to their natural-order slot.
    always_ff @(posedge clk) begin
        if (accept) begin
            mem[wr_bank][bitrev(wr_cnt)] <= in_data;
        end
    end

    // Write pointer: advance per accepted word, switch bank at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_cnt  <= '0;
            wr_bank <= 1'b0;
        end else if (accept) begin
            wr_cnt <= wr_cnt + 1'b1;
            if (wr_cnt == '1) begin
                wr_bank <= ~wr_bank;
            end
        end
    end

    // Read pointer: advance per transferred word, switch bank at frame end.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rd_cnt  <= '0;
            rd_bank <= 1'b0;
        end else if (xfer) begin
            rd_cnt <= rd_cnt + 1'b1;
            if (rd_cnt == '1) begin
                rd_bank <= ~rd_bank;
            end
        end
    end

    // Bank occupancy: fill and drain act on different banks, so both apply.
    always_comb begin
        full_nxt = full;
        if (accept && (wr_cnt == '1)) begin
            full_nxt[wr_bank] = 1'b1;
        end
        if (xfer && (rd_cnt == '1)) begin
            full_nxt[rd_bank] = 1'b0;
        end
    end

    // Occupancy register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            full <= 2'b00;
        end else begin
            full <= full_nxt;
        end
    end

endmodule

// File: tb/tb_fft_reorder.sv
// tb/tb_fft_reorder.sv - scoreboard testbench for fft_reorder
module tb_fft_reorder;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic [31:0] in_data = '0;
    logic        in_ready;
    logic        out_valid;
    logic [31:0] out_data;
    logic        out_ready = 1'b0;
    logic [3:0]  out_index;
    logic        out_last;

    fft_reorder #(.N_LOG2(4), .DW(32)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_data   (in_data),
        .in_ready  (in_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .out_index (out_index),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] data;
        logic [3:0]  idx;
        logic        last;
    } exp_t;

    // hand-computed: natural output bin i comes from input position rev_tab[i]
    int          rev_tab [16] = '{0, 8, 4, 12, 2, 10, 6, 14, 1, 9, 5, 13, 3, 11, 7, 15};
    exp_t        sb [$];
    int          xfer_cyc [$];
    logic [31:0] frame_buf [16];
    int          wr_pos = 0;
    int          tests = 0;
    int          fails = 0;
    int          stalls = 0;
    int          cyc = 0;
    int          ready_mode = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) cyc++;

    always @(posedge clk) begin
        #2;
        case (ready_mode)
            0:       out_ready = 1'b0;
            1:       out_ready = 1'b1;
            default: out_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // monitor: pop and compare on every transfer
    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                check("unexpected_output", 32'd1, 32'd0);
            end else begin
                exp_t e;
                e = sb.pop_front();
                check("out_data", out_data, e.data);
                check("out_index", {28'd0, out_index}, {28'd0, e.idx});
                check("out_last", {31'd0, out_last}, {31'd0, e.last});
            end
            xfer_cyc.push_back(cyc);
        end
    end

    task automatic send(input logic [31:0] d, input int gap);
        int n;
        in_valid = 1'b0;
        repeat (gap) begin
            @(posedge clk);
            #1;
        end
        in_valid = 1'b1;
        in_data  = d;
        n = 0;
        @(negedge clk);
        while (!in_ready && n < 300) begin
            n++;
            stalls++;
            @(negedge clk);
        end
        if (!in_ready) begin
            check("send_timeout", 32'd1, 32'd0);
            in_valid = 1'b0;
        end else begin
            @(posedge clk);
            #1;
            in_valid = 1'b0;
            frame_buf[wr_pos] = d;
            wr_pos++;
            if (wr_pos == 16) begin
                for (int i = 0; i < 16; i++) begin
                    exp_t e;
                    e.data = frame_buf[rev_tab[i]];
                    e.idx  = 4'(i);
                    e.last = (i == 15);
                    sb.push_back(e);
                end
                wr_pos = 0;
            end
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() != 0 && n < 3000) begin
            @(negedge clk);
            n++;
        end
        check("drain_timeout", 32'(sb.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int idx0;
        #1;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_out_index", {28'd0, out_index}, 32'd0);
        check("rst_out_last", {31'd0, out_last}, 32'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 1;
        @(posedge clk);
        #1;

        // single frame, latency
        for (int k = 0; k < 16; k++) begin
            if (k == 15) check("pre_last_out_valid", {31'd0, out_valid}, 32'd0);
            send(32'(k), 0);
        end
        check("latency_out_valid", {31'd0, out_valid}, 32'd1);
        drain();

        // continuous streaming
        stalls = 0;
        idx0 = xfer_cyc.size();
        for (int f = 0; f < 4; f++) begin
            for (int k = 0; k < 16; k++) begin
                send({16'(f), 16'(k)}, 0);
            end
        end
        drain();
        check("stream_stalls", 32'(stalls), 32'd0);
        check("stream_count", 32'(xfer_cyc.size() - idx0), 32'd64);
        if (xfer_cyc.size() - idx0 >= 64) begin
            check("stream_contiguous", 32'(xfer_cyc[idx0 + 63] - xfer_cyc[idx0]), 32'd63);
        end

        // backpressure
        ready_mode = 0;
        repeat (2) @(posedge clk);
        #1;
        for (int k = 0; k < 32; k++) begin
            send({16'h00b0 + 16'(k / 16), 16'(k % 16)}, 0);
        end
        check("bp_in_ready_low", {31'd0, in_ready}, 32'd0);
        fork
            send(32'hcafe_0000, 0);
            begin
                repeat (4) begin
                    @(negedge clk);
                    check("bp_hold_valid", {31'd0, out_valid}, 32'd1);
                    check("bp_hold_data", out_data, 32'h00b0_0000);
                    check("bp_hold_index", {28'd0, out_index}, 32'd0);
                end
                @(posedge clk);
                #1;
                ready_mode = 1;
                repeat (16) @(negedge clk);
                check("bp_in_ready_before_free", {31'd0, in_ready}, 32'd0);
                @(negedge clk);
                check("bp_in_ready_after_free", {31'd0, in_ready}, 32'd1);
            end
        join
        for (int k = 1; k < 16; k++) begin
            send(32'hcafe_0000 + 32'(k), 0);
        end
        drain();

        // random stalls
        ready_mode = 2;
        for (int f = 0; f < 20; f++) begin
            for (int k = 0; k < 16; k++) begin
                send($urandom, $urandom_range(0, 1) * $urandom_range(1, 2));
            end
        end
        ready_mode = 1;
        drain();

        // reset mid-operation
        ready_mode = 0;
        for (int k = 0; k < 16; k++) send(32'h0dd0_0000 + 32'(k), 0);
        ready_mode = 1;
        repeat (8) @(posedge clk);
        #1;
        ready_mode = 0;
        for (int k = 0; k < 7; k++) send(32'h0dd1_0000 + 32'(k), 0);
        @(posedge clk);
        #3;
        rst = 1'b1;
        #1;
        check("mid_rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("mid_rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("mid_rst_out_index", {28'd0, out_index}, 32'd0);
        sb.delete();
        wr_pos = 0;
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        ready_mode = 1;
        for (int k = 0; k < 16; k++) send(32'h0dd2_0000 + 32'(k), 0);
        drain();

        // signed extremes at input positions 1 and 3
        for (int k = 0; k < 16; k++) begin
            if (k == 1)      send(32'h8000_7fff, 0);
            else if (k == 3) send(32'h7fff_8000, 0);
            else             send(32'h0000_1000 + 32'(k), 0);
        end
        drain();

        repeat (4) @(posedge clk);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
